soc_run_ctrl: RTL and testbench

- Synthesizable run controller for the RISC-V SoC top: sequences core reset, generates per-channel periodic interrupts, watches the core trap line, enforces a cycle timeout and reports pass/fail.
- Parametrised generalisation of the fixed reset / interrupt / timeout harness: N interrupt channels, programmable periods, reset hold length and timeout.
- Sits beside the core; drives the core reset and interrupt inputs, samples `io_trap` and the LED bus.

---
 rtl/soc_run_pkg.sv | 13 +
 rtl/soc_run_ctrl_irq_timer.sv | 37 +++
 rtl/soc_run_ctrl.sv | 101 ++++++++++
 tb/tb_soc_run_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_run_pkg.sv
// soc_run_pkg: run-controller state encoding and default run parameters.
package soc_run_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_PASS = 3'd3,
        ST_FAIL = 3'd4
    } run_state_e;

    localparam logic [7:0] PASS_LEDS_DEF = 8'hA5;
    localparam int         TIMEOUT_DEF   = 10000;
endpackage

// File: rtl/soc_run_ctrl_irq_timer.sv
// irq_timer: one periodic interrupt channel with a sticky, ack-cleared pending bit.
module irq_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               active,
    input  logic               clr,
    input  logic               keep,
    input  logic               en,
    input  logic [TIMER_W-1:0] period,
    input  logic               ack,
    output logic               pending
);
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               pending_q, pending_d, armed, wrap;

    // A timer already past a shrunken period keeps counting and wraps at 2^TIMER_W.
    always_comb begin
        armed     = active && en && period != '0;
        wrap      = armed && timer_q == period - TIMER_W'(1);
        timer_d   = clr ? '0 : !active ? timer_q : (!armed || wrap) ? '0 : timer_q + TIMER_W'(1);
        pending_d = keep && (wrap || (pending_q && !ack));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;
endmodule

// File: rtl/soc_run_ctrl.sv
// soc_run_ctrl: sequences core reset, drives periodic interrupts, and judges
// the run by trap LEDs or a cycle timeout.
module soc_run_ctrl
    import soc_run_pkg::*;
#(
    parameter int               RESET_CYCLES = 10,
    parameter int               NUM_IRQ      = 4,
    parameter int               TIMER_W      = 32,
    parameter int               TIMEOUT      = TIMEOUT_DEF,
    parameter int               LED_W        = 8,
    parameter logic [LED_W-1:0] PASS_LEDS    = LED_W'(PASS_LEDS_DEF)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_IRQ-1:0]         irq_en,
    input  logic [NUM_IRQ*TIMER_W-1:0] irq_period,
    input  logic [NUM_IRQ-1:0]         irq_ack,
    input  logic                       trap_in,
    input  logic [LED_W-1:0]           leds_in,
    output logic                       core_reset,
    output logic [NUM_IRQ-1:0]         irq_out,
    output logic [2:0]                 state,
    output logic                       done,
    output logic                       pass,
    output logic [31:0]                cycles,
    output logic [LED_W-1:0]           leds_final
);
    run_state_e       state_q, state_d;
    logic [31:0]      hold_q, hold_d, cycles_q, cycles_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic             core_reset_q, core_reset_d, done_q, done_d, pass_q, pass_d;
    logic             hold_entry, in_run, stay_run, run_end;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE, ST_PASS, ST_FAIL: if (start) begin
                state_d = ST_HOLD;
                hold_d  = '0;
            end
            ST_HOLD: if (hold_q == 32'(RESET_CYCLES - 1)) state_d = ST_RUN;
                     else hold_d = hold_q + 32'd1;
            ST_RUN: if (trap_in) state_d = (leds_in == PASS_LEDS) ? ST_PASS : ST_FAIL;
                    else if (cycles_q == 32'(TIMEOUT - 1)) state_d = ST_FAIL;
            default: state_d = ST_IDLE;
        endcase
        hold_entry   = state_d == ST_HOLD && state_q != ST_HOLD;
        in_run       = state_q == ST_RUN;
        stay_run     = state_d == ST_RUN;
        run_end      = in_run && !stay_run;
        cycles_d     = hold_entry ? '0 : (in_run && cycles_q != '1) ? cycles_q + 32'd1 : cycles_q;
        leds_d       = hold_entry ? '0 : run_end ? leds_in : leds_q;
        core_reset_d = !stay_run;
        done_d       = state_d == ST_PASS || state_d == ST_FAIL;
        pass_d       = state_d == ST_PASS;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            cycles_q     <= '0;
            leds_q       <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycles_q     <= cycles_d;
            leds_q       <= leds_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    // Pending bits only survive into cycles that are still RUN.
    for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
        irq_timer #(.TIMER_W(TIMER_W)) u_irq (
            .clock   (clock),
            .reset_n (reset_n),
            .active  (in_run),
            .clr     (hold_entry),
            .keep    (stay_run),
            .en      (irq_en[k]),
            .period  (irq_period[k*TIMER_W +: TIMER_W]),
            .ack     (irq_ack[k]),
            .pending (irq_out[k])
        );
    end

    assign state      = state_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign cycles     = cycles_q;
    assign leds_final = leds_q;
endmodule

// File: tb/tb_soc_run_ctrl.sv
// tb_soc_run_ctrl: directed and randomized runs checked every cycle against a
// behavioural model, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_soc_run_ctrl;
    localparam int         RC = 10, NI = 4, TW = 32, TO = 100, LW = 8;
    localparam logic [7:0] PL = 8'hA5;

    logic             clock = 0, reset_n = 1, start = 0, trap_in = 0;
    logic [NI-1:0]    irq_en = '0, irq_ack = '0;
    logic [NI*TW-1:0] irq_period = '0;
    logic [LW-1:0]    leds_in = '0;
    logic             core_reset, done, pass;
    logic [NI-1:0]    irq_out;
    logic [2:0]       state;
    logic [31:0]      cycles;
    logic [LW-1:0]    leds_final;

    int     n_chk = 0, n_err = 0;
    bit     chk_on = 0;
    int     m_state, m_hold;
    longint m_cyc, m_tmr [NI];
    logic [NI-1:0] m_irq;
    logic [LW-1:0] m_leds;
    logic   m_cr, m_done, m_pass;

    soc_run_ctrl #(
        .RESET_CYCLES(RC), .NUM_IRQ(NI), .TIMER_W(TW), .TIMEOUT(TO), .LED_W(LW), .PASS_LEDS(PL)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .irq_en(irq_en),
        .irq_period(irq_period), .irq_ack(irq_ack), .trap_in(trap_in), .leds_in(leds_in),
        .core_reset(core_reset), .irq_out(irq_out), .state(state), .done(done),
        .pass(pass), .cycles(cycles), .leds_final(leds_final)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic set_per(int k, int v);
        irq_period[k*TW +: TW] = TW'(v);
    endtask

    // Reference model: the run described as phases, counters and per-channel periods.
    always @(posedge clock or negedge reset_n) begin : mdl
        int st, hc;
        longint cy, per;
        longint tm [NI];
        logic [NI-1:0] ir;
        logic [LW-1:0] lf;
        bit wr;
        if (!reset_n) begin
            m_state <= 0; m_hold <= 0; m_cyc <= 0; m_irq <= '0; m_leds <= '0;
            m_cr <= 1; m_done <= 0; m_pass <= 0; m_tmr <= '{default: 0};
        end else begin
            st = m_state; hc = m_hold; cy = m_cyc; ir = m_irq; lf = m_leds; tm = m_tmr;
            if ((st == 0 || st >= 3) && start) begin
                st = 1; hc = 0; cy = 0; ir = '0; lf = '0; tm = '{default: 0};
            end else if (st == 1) begin
                if (hc == RC - 1) st = 2; else hc++;
            end else if (st == 2) begin
                for (int k = 0; k < NI; k++) begin
                    per = longint'(irq_period[k*TW +: TW]);
                    wr = 0;
                    if (irq_en[k] && per != 0) begin
                        wr = tm[k] == per - 1;
                        tm[k] = wr ? 0 : (tm[k] + 1) & 64'hFFFF_FFFF;
                    end else tm[k] = 0;
                    ir[k] = wr | (ir[k] & ~irq_ack[k]);
                end
                if (trap_in) begin st = (leds_in == PL) ? 3 : 4; lf = leds_in; end
                else if (cy == TO - 1) begin st = 4; lf = leds_in; end
                if (cy != 64'hFFFF_FFFF) cy++;
                if (st != 2) ir = '0;
            end
            m_state <= st; m_hold <= hc; m_cyc <= cy; m_irq <= ir; m_leds <= lf; m_tmr <= tm;
            m_cr <= st != 2; m_done <= st >= 3; m_pass <= st == 3;
        end
    end

    always @(negedge clock) if (chk_on) begin
        chk("cmp_state", state, m_state);
        chk("cmp_core_reset", core_reset, m_cr);
        chk("cmp_irq_out", irq_out, m_irq);
        chk("cmp_done", done, m_done);
        chk("cmp_pass", pass, m_pass);
        chk("cmp_cycles", cycles, m_cyc);
        chk("cmp_leds_final", leds_final, m_leds);
    end

    task automatic pulse_start;
        @(negedge clock) start = 1;
        @(negedge clock) start = 0;
    endtask

    task automatic wait_run;
        int n = 0;
        while (state != 2 && n < 50) begin n++; @(negedge clock); end
        chk("run_entry", state, 2);
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        int n;
        #1 reset_n = 0;
        repeat (3) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_irq", irq_out, 0);
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles, 0);
        reset_n = 1;
        chk_on = 1;

        // Reset hold length and interrupt timing on the first run.
        irq_en = 4'b0011; set_per(0, 20); set_per(1, 0); set_per(2, 5);
        pulse_start;
        chk("hold_state", state, 1);
        n = 0;
        while (core_reset && n < 50) begin n++; @(negedge clock); end
        chk("hold_len", n, RC);
        chk("run_state", state, 2);
        n = 0;
        while (!irq_out[0] && n < 100) begin n++; @(negedge clock); end
        chk("irq0_delay", n, 20);
        repeat (5) @(negedge clock);
        chk("irq0_sticky", irq_out[0], 1);
        irq_ack[0] = 1;
        @(negedge clock);
        chk("irq0_acked", irq_out[0], 0);
        chk("cycles_26", cycles, 26);
        irq_ack[0] = 0;
        repeat (13) @(negedge clock);
        irq_ack[0] = 1;
        @(negedge clock);
        chk("ack_vs_wrap", irq_out[0], 1);
        irq_ack[0] = 0;
        @(negedge clock);
        chk("irq_mask", irq_out, 4'b0001);
        repeat (9) @(negedge clock);
        trap_in = 1; leds_in = PL;
        @(negedge clock);
        trap_in = 0; leds_in = '0;
        chk("pass_state", state, 3);
        chk("pass_done", done, 1);
        chk("pass_pass", pass, 1);
        chk("pass_leds", leds_final, PL);
        chk("pass_cycles", cycles, 51);
        chk("pass_core_reset", core_reset, 1);
        chk("pass_irq", irq_out, 0);

        // Restart from PASS, then fail on wrong LEDs.
        irq_en = '0;
        pulse_start;
        chk("restart_state", state, 1);
        chk("restart_done", done, 0);
        chk("restart_cycles", cycles, 0);
        chk("restart_leds", leds_final, 0);
        wait_run;
        repeat (7) @(negedge clock);
        trap_in = 1; leds_in = 8'h01;
        @(negedge clock);
        trap_in = 0;
        chk("fail_state", state, 4);
        chk("fail_pass", pass, 0);
        chk("fail_leds", leds_final, 8'h01);
        chk("fail_cycles", cycles, 8);

        // Timeout with no trap.
        leds_in = 8'h3C;
        pulse_start;
        wait_run;
        n = 0;
        while (!done && n < 300) begin n++; @(negedge clock); end
        chk("to_delay", n, TO);
        chk("to_state", state, 4);
        chk("to_cycles", cycles, TO);
        chk("to_leds", leds_final, 8'h3C);

        // Trap on the last budgeted cycle beats the timeout.
        pulse_start;
        wait_run;
        repeat (TO - 1) @(negedge clock);
        trap_in = 1; leds_in = 8'h77;
        @(negedge clock);
        trap_in = 0; leds_in = '0;
        chk("trap99_state", state, 4);
        chk("trap99_leds", leds_final, 8'h77);
        chk("trap99_cycles", cycles, TO);

        // Asynchronous reset mid-RUN with two pending interrupts.
        irq_en = 4'b0011; set_per(0, 1); set_per(1, 3);
        pulse_start;
        wait_run;
        repeat (5) @(negedge clock);
        chk("pre_arst_irq", irq_out, 4'b0011);
        #2 reset_n = 0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_core_reset", core_reset, 1);
        chk("arst_irq", irq_out, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_cycles", cycles, 0);
        chk("arst_leds", leds_final, 0);
        @(negedge clock) reset_n = 1;

        // Randomized runs against the model.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NI; k++)
                set_per(k, ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 30)));
            irq_en = NI'($urandom);
            pulse_start;
            wait_run;
            n = 0;
            while (!done && n < 300) begin
                irq_ack = NI'($urandom) & NI'($urandom);
                if ($urandom_range(0, 15) == 0) irq_en = NI'($urandom);
                if ($urandom_range(0, 31) == 0) set_per(int'($urandom_range(0, NI - 1)), int'($urandom_range(0, 30)));
                start   = $urandom_range(0, 20) == 0;
                trap_in = $urandom_range(0, 80) == 0;
                leds_in = $urandom_range(0, 1) != 0 ? PL : LW'($urandom);
                @(negedge clock);
                n++;
            end
            chk("rand_done", done, 1);
            trap_in = 0; start = 0; irq_ack = '0;
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        chk_on = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
